// File: rtl/chip8_fetch_decode_if.sv
// Fetch/decode bus bundle: program-memory read port, pc redirect from execute,
// and the decoded-instruction valid/ready channel toward execute.
interface chip8_fetch_decode_if #(
   parameter int unsigned ADDR_W = 12
);
   logic              mem_rd;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_rdata;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_addr;
   logic              out_valid;
   logic              out_ready;
   logic [ADDR_W-1:0] out_pc;
   logic [15:0]       out_opcode;
   logic [3:0]        out_leader;
   logic [3:0]        out_rx;
   logic [3:0]        out_ry;
   logic [3:0]        out_nibble;
   logic [7:0]        out_imm8;
   logic [ADDR_W-1:0] out_addr;
   logic [5:0]        out_op_id;
   logic              out_illegal;

   modport master (
      output mem_rd, mem_addr, out_valid, out_pc, out_opcode, out_leader, out_rx,
             out_ry, out_nibble, out_imm8, out_addr, out_op_id, out_illegal,
      input  mem_rdata, redirect, redirect_addr, out_ready
   );

   modport slave (
      input  mem_rd, mem_addr, out_valid, out_pc, out_opcode, out_leader, out_rx,
             out_ry, out_nibble, out_imm8, out_addr, out_op_id, out_illegal,
      output mem_rdata, redirect, redirect_addr, out_ready
   );
endinterface

// File: rtl/chip8_fetch_decode.sv
// Chip8 fetch + decode: reads a big-endian opcode at pc over two cycles, classifies it
// and holds the registered instruction until execute takes it or redirects the pc.
module chip8_fetch_decode #(
   parameter int unsigned       ADDR_W    = 12,
   parameter logic [ADDR_W-1:0] PC_RESET  = ADDR_W'('h200),
   parameter bit                EXT_SCHIP = 1'b0
) (
   input logic                 clk,
   input logic                 rst,
   chip8_fetch_decode_if.master bus
);

   typedef enum logic [1:0] {F_HI, F_LO, CAP, VALID} state_e;

   function automatic logic [5:0] decode_op(input logic [15:0] op);
      logic [3:0] n;
      logic [7:0] kk;
      logic [5:0] id;
      n  = op[3:0];
      kk = op[7:0];
      id = 6'd0;
      case (op[15:12])
         4'h0: begin
            if (op == 16'h00E0)                                      id = 6'd1;
            else if (op == 16'h00EE)                                 id = 6'd2;
            else if (EXT_SCHIP && op[15:4] == 12'h00C)               id = 6'd36;
            // 00FB..00FF map onto consecutive ids 37..41
            else if (EXT_SCHIP && op[15:4] == 12'h00F && n >= 4'hB)  id = 6'd37 + {2'b00, n - 4'hB};
            else                                                     id = 6'd3;
         end
         4'h1: id = 6'd4;
         4'h2: id = 6'd5;
         4'h3: id = 6'd6;
         4'h4: id = 6'd7;
         4'h5: id = (n == 4'h0) ? 6'd8 : 6'd0;
         4'h6: id = 6'd9;
         4'h7: id = 6'd10;
         4'h8: begin
            if (n <= 4'h7)       id = 6'd11 + {2'b00, n};
            else if (n == 4'hE)  id = 6'd19;
         end
         4'h9: id = (n == 4'h0) ? 6'd20 : 6'd0;
         4'hA: id = 6'd21;
         4'hB: id = 6'd22;
         4'hC: id = 6'd23;
         4'hD: id = 6'd24;
         4'hE: begin
            if (kk == 8'h9E)       id = 6'd25;
            else if (kk == 8'hA1)  id = 6'd26;
         end
         4'hF: begin
            case (kk)
               8'h07:   id = 6'd27;
               8'h0A:   id = 6'd28;
               8'h15:   id = 6'd29;
               8'h18:   id = 6'd30;
               8'h1E:   id = 6'd31;
               8'h29:   id = 6'd32;
               8'h33:   id = 6'd33;
               8'h55:   id = 6'd34;
               8'h65:   id = 6'd35;
               8'h30:   id = EXT_SCHIP ? 6'd42 : 6'd0;
               8'h75:   id = EXT_SCHIP ? 6'd43 : 6'd0;
               8'h85:   id = EXT_SCHIP ? 6'd44 : 6'd0;
               default: id = 6'd0;
            endcase
         end
      endcase
      return id;
   endfunction

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [7:0]        hi_q, hi_d;
   logic              valid_q, valid_d;
   logic [ADDR_W-1:0] out_pc_q;
   logic [15:0]       op_q;
   logic [5:0]        op_id_q;
   logic              illegal_q;

   logic              capture;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [15:0]       cap_op;
   logic [5:0]        cap_id;

   assign cap_op = {hi_q, bus.mem_rdata};
   assign cap_id = decode_op(cap_op);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      hi_d    = hi_q;
      valid_d = valid_q;
      capture = 1'b0;
      rd_en   = 1'b0;
      rd_addr = pc_q;
      case (state_q)
         F_HI: begin
            rd_en   = 1'b1;
            state_d = F_LO;
         end
         F_LO: begin
            hi_d    = bus.mem_rdata;
            rd_en   = 1'b1;
            rd_addr = pc_q + ADDR_W'(1);
            state_d = CAP;
         end
         CAP: begin
            capture = 1'b1;
            valid_d = 1'b1;
            state_d = VALID;
         end
         VALID: begin
            if (bus.out_ready) begin
               valid_d = 1'b0;
               pc_d    = pc_q + ADDR_W'(2);
               state_d = F_HI;
            end
         end
         default: state_d = F_HI;
      endcase
      // A redirect overrides everything, including a same-cycle handshake or capture
      if (bus.redirect) begin
         pc_d    = bus.redirect_addr;
         state_d = F_HI;
         valid_d = 1'b0;
         capture = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= F_HI;
         pc_q      <= PC_RESET;
         hi_q      <= 8'h00;
         valid_q   <= 1'b0;
         out_pc_q  <= '0;
         op_q      <= 16'h0000;
         op_id_q   <= 6'd0;
         illegal_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         hi_q    <= hi_d;
         valid_q <= valid_d;
         if (capture) begin
            out_pc_q  <= pc_q;
            op_q      <= cap_op;
            op_id_q   <= cap_id;
            illegal_q <= (cap_id == 6'd0);
         end
      end
   end

   assign bus.mem_rd      = rd_en;
   assign bus.mem_addr    = rd_addr;
   assign bus.out_valid   = valid_q;
   assign bus.out_pc      = out_pc_q;
   assign bus.out_opcode  = op_q;
   assign bus.out_leader  = op_q[15:12];
   assign bus.out_rx      = op_q[11:8];
   assign bus.out_ry      = op_q[7:4];
   assign bus.out_nibble  = op_q[3:0];
   assign bus.out_imm8    = op_q[7:0];
   assign bus.out_addr    = ADDR_W'(op_q[11:0]);
   assign bus.out_op_id   = op_id_q;
   assign bus.out_illegal = illegal_q;

endmodule

// File: tb/tb_chip8_fetch_decode.sv
// Bench for chip8_fetch_decode: two instances (base and SUPER-CHIP decode) share one
// program memory and the same control stimulus; results are checked against a pattern-table model.
module tb_chip8_fetch_decode;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect = 1'b0;
   logic [11:0] redirect_addr = 12'h000;
   logic        out_ready = 1'b0;
   logic [7:0]  mem [0:4095];
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   chip8_fetch_decode_if #(.ADDR_W(12)) bus0 ();
   chip8_fetch_decode_if #(.ADDR_W(12)) bus1 ();

   assign bus0.redirect      = redirect;
   assign bus0.redirect_addr = redirect_addr;
   assign bus0.out_ready     = out_ready;
   assign bus1.redirect      = redirect;
   assign bus1.redirect_addr = redirect_addr;
   assign bus1.out_ready     = out_ready;

   always @(posedge clk) if (bus0.mem_rd) bus0.mem_rdata <= mem[bus0.mem_addr];
   always @(posedge clk) if (bus1.mem_rd) bus1.mem_rdata <= mem[bus1.mem_addr];

   chip8_fetch_decode #(.ADDR_W(12), .PC_RESET(12'h200), .EXT_SCHIP(1'b0)) dut0 (
      .clk(clk), .rst(rst), .bus(bus0.master));
   chip8_fetch_decode #(.ADDR_W(12), .PC_RESET(12'h200), .EXT_SCHIP(1'b1)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1.master));

   // Reference decoder: ordered (mask, value) patterns, first hit wins, no hit = illegal
   typedef struct {
      logic [15:0] mask;
      logic [15:0] val;
      int          id;
      bit          schip;
   } pat_t;
   pat_t pats[$];

   function automatic void add(input logic [15:0] m, input logic [15:0] v, input int id, input bit s);
      pat_t p;
      p.mask = m; p.val = v; p.id = id; p.schip = s;
      pats.push_back(p);
   endfunction

   function automatic void build_table();
      add(16'hFFFF, 16'h00E0, 1, 0);  add(16'hFFFF, 16'h00EE, 2, 0);
      add(16'hFFF0, 16'h00C0, 36, 1);
      for (int i = 0; i < 5; i++) add(16'hFFFF, 16'h00FB + 16'(i), 37 + i, 1);
      add(16'hF000, 16'h0000, 3, 0);  add(16'hF000, 16'h1000, 4, 0);
      add(16'hF000, 16'h2000, 5, 0);  add(16'hF000, 16'h3000, 6, 0);
      add(16'hF000, 16'h4000, 7, 0);  add(16'hF00F, 16'h5000, 8, 0);
      add(16'hF000, 16'h6000, 9, 0);  add(16'hF000, 16'h7000, 10, 0);
      for (int i = 0; i < 8; i++) add(16'hF00F, 16'h8000 + 16'(i), 11 + i, 0);
      add(16'hF00F, 16'h800E, 19, 0); add(16'hF00F, 16'h9000, 20, 0);
      add(16'hF000, 16'hA000, 21, 0); add(16'hF000, 16'hB000, 22, 0);
      add(16'hF000, 16'hC000, 23, 0); add(16'hF000, 16'hD000, 24, 0);
      add(16'hF0FF, 16'hE09E, 25, 0); add(16'hF0FF, 16'hE0A1, 26, 0);
      add(16'hF0FF, 16'hF007, 27, 0); add(16'hF0FF, 16'hF00A, 28, 0);
      add(16'hF0FF, 16'hF015, 29, 0); add(16'hF0FF, 16'hF018, 30, 0);
      add(16'hF0FF, 16'hF01E, 31, 0); add(16'hF0FF, 16'hF029, 32, 0);
      add(16'hF0FF, 16'hF033, 33, 0); add(16'hF0FF, 16'hF055, 34, 0);
      add(16'hF0FF, 16'hF065, 35, 0); add(16'hF0FF, 16'hF030, 42, 1);
      add(16'hF0FF, 16'hF075, 43, 1); add(16'hF0FF, 16'hF085, 44, 1);
   endfunction

   function automatic int ref_id(input logic [15:0] op, input bit schip);
      foreach (pats[i])
         if ((!pats[i].schip || schip) && ((op & pats[i].mask) == pats[i].val)) return pats[i].id;
      return 0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [11:0] a, input logic [15:0] op);
      logic [11:0] a1;
      a1 = a + 12'd1;
      mem[a]  = op[15:8];
      mem[a1] = op[7:0];
   endtask

   // Redirect to a, then run the four cycles that end with the instruction presented
   task automatic goto(input logic [11:0] a);
      out_ready     = 1'b0;
      redirect      = 1'b1;
      redirect_addr = a;
      tick();
      redirect = 1'b0;
      tick(); tick(); tick();
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      out_ready = 1'b1;
      put(12'h200, 16'h1234);
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (bus0.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %0h want 0", bus0.out_valid); end
      n_cmp++; if (bus0.out_opcode !== 16'h0 || bus0.out_pc !== 12'h0 || bus0.out_op_id !== 6'd0 || bus0.out_illegal !== 1'b0)
         begin n_err++; $display("FAIL rst_outs: got op=%h pc=%h id=%0d ill=%0h want all 0", bus0.out_opcode, bus0.out_pc, bus0.out_op_id, bus0.out_illegal); end
      n_cmp++; if (bus0.mem_addr !== 12'h200) begin n_err++; $display("FAIL rst_addr: got %h want 200", bus0.mem_addr); end
      rst = 1'b0;
   endtask

   task automatic test_first_fetch();
      n_cmp++; if (bus0.mem_rd !== 1'b1 || bus0.mem_addr !== 12'h200) begin n_err++; $display("FAIL ff_rd_hi: got rd=%0h addr=%h want 1/200", bus0.mem_rd, bus0.mem_addr); end
      tick();
      n_cmp++; if (bus0.mem_rd !== 1'b1 || bus0.mem_addr !== 12'h201) begin n_err++; $display("FAIL ff_rd_lo: got rd=%0h addr=%h want 1/201", bus0.mem_rd, bus0.mem_addr); end
      tick();
      n_cmp++; if (bus0.out_valid !== 1'b0 || bus0.mem_rd !== 1'b0) begin n_err++; $display("FAIL ff_cap: got valid=%0h rd=%0h want 0/0", bus0.out_valid, bus0.mem_rd); end
      tick();
      n_cmp++; if (bus0.out_valid !== 1'b1 || bus0.out_opcode !== 16'h1234 || bus0.out_pc !== 12'h200)
         begin n_err++; $display("FAIL ff_out: got valid=%0h op=%h pc=%h want 1/1234/200", bus0.out_valid, bus0.out_opcode, bus0.out_pc); end
      n_cmp++; if (bus0.out_op_id !== 6'd4 || bus0.out_addr !== 12'h234 || bus0.out_illegal !== 1'b0)
         begin n_err++; $display("FAIL ff_dec: got id=%0d addr=%h ill=%0h want 4/234/0", bus0.out_op_id, bus0.out_addr, bus0.out_illegal); end
      tick();
      n_cmp++; if (bus0.out_valid !== 1'b0 || bus0.mem_rd !== 1'b1 || bus0.mem_addr !== 12'h202)
         begin n_err++; $display("FAIL ff_next: got valid=%0h rd=%0h addr=%h want 0/1/202", bus0.out_valid, bus0.mem_rd, bus0.mem_addr); end
   endtask

   task automatic test_stall();
      out_ready = 1'b0;
      put(12'h202, 16'h8AB4);
      tick(); tick(); tick();
      n_cmp++; if (bus0.out_rx !== 4'hA || bus0.out_ry !== 4'hB || bus0.out_nibble !== 4'h4 || bus0.out_imm8 !== 8'hB4)
         begin n_err++; $display("FAIL st_fields: got rx=%h ry=%h n=%h kk=%h want A/B/4/B4", bus0.out_rx, bus0.out_ry, bus0.out_nibble, bus0.out_imm8); end
      n_cmp++; if (bus0.out_op_id !== 6'd15) begin n_err++; $display("FAIL st_id: got %0d want 15", bus0.out_op_id); end
      for (int i = 0; i < 10; i++) begin
         tick();
         n_cmp++; if (bus0.out_valid !== 1'b1 || bus0.out_opcode !== 16'h8AB4 || bus0.mem_rd !== 1'b0)
            begin n_err++; $display("FAIL st_hold%0d: got valid=%0h op=%h rd=%0h want 1/8AB4/0", i, bus0.out_valid, bus0.out_opcode, bus0.mem_rd); end
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_cmp++; if (bus0.out_valid !== 1'b0 || bus0.mem_addr !== 12'h204) begin n_err++; $display("FAIL st_next: got valid=%0h addr=%h want 0/204", bus0.out_valid, bus0.mem_addr); end
   endtask

   task automatic test_redirect_flo();
      put(12'h204, 16'h1111);
      put(12'h300, 16'hA123);
      tick();
      redirect = 1'b1; redirect_addr = 12'h300;
      tick();
      redirect = 1'b0;
      n_cmp++; if (bus0.out_valid !== 1'b0 || bus0.mem_rd !== 1'b1 || bus0.mem_addr !== 12'h300)
         begin n_err++; $display("FAIL rf_addr: got valid=%0h rd=%0h addr=%h want 0/1/300", bus0.out_valid, bus0.mem_rd, bus0.mem_addr); end
      tick(); tick();
      n_cmp++; if (bus0.out_valid !== 1'b0) begin n_err++; $display("FAIL rf_novalid: got %0h want 0", bus0.out_valid); end
      tick();
      n_cmp++; if (bus0.out_valid !== 1'b1 || bus0.out_pc !== 12'h300 || bus0.out_opcode !== 16'hA123 || bus0.out_op_id !== 6'd21)
         begin n_err++; $display("FAIL rf_out: got valid=%0h pc=%h op=%h id=%0d want 1/300/A123/21", bus0.out_valid, bus0.out_pc, bus0.out_opcode, bus0.out_op_id); end
   endtask

   task automatic test_wrap();
      put(12'hFFF, 16'h00E0);
      redirect = 1'b1; redirect_addr = 12'hFFF;
      tick();
      redirect = 1'b0;
      n_cmp++; if (bus0.mem_addr !== 12'hFFF) begin n_err++; $display("FAIL wr_hi: got %h want FFF", bus0.mem_addr); end
      tick();
      n_cmp++; if (bus0.mem_rd !== 1'b1 || bus0.mem_addr !== 12'h000) begin n_err++; $display("FAIL wr_lo: got rd=%0h addr=%h want 1/000", bus0.mem_rd, bus0.mem_addr); end
      tick(); tick();
      n_cmp++; if (bus0.out_pc !== 12'hFFF || bus0.out_opcode !== 16'h00E0 || bus0.out_op_id !== 6'd1)
         begin n_err++; $display("FAIL wr_out: got pc=%h op=%h id=%0d want FFF/00E0/1", bus0.out_pc, bus0.out_opcode, bus0.out_op_id); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_cmp++; if (bus0.mem_addr !== 12'h001) begin n_err++; $display("FAIL wr_next: got %h want 001", bus0.mem_addr); end
   endtask

   task automatic test_redirect_cap();
      put(12'h400, 16'h6A55);
      tick(); tick();
      redirect = 1'b1; redirect_addr = 12'h400;
      tick();
      redirect = 1'b0;
      n_cmp++; if (bus0.out_valid !== 1'b0 || bus0.mem_addr !== 12'h400 || bus0.out_opcode !== 16'h00E0)
         begin n_err++; $display("FAIL rc_drop: got valid=%0h addr=%h op=%h want 0/400/00E0", bus0.out_valid, bus0.mem_addr, bus0.out_opcode); end
      tick(); tick(); tick();
      n_cmp++; if (bus0.out_valid !== 1'b1 || bus0.out_opcode !== 16'h6A55 || bus0.out_op_id !== 6'd9)
         begin n_err++; $display("FAIL rc_out: got valid=%0h op=%h id=%0d want 1/6A55/9", bus0.out_valid, bus0.out_opcode, bus0.out_op_id); end
      out_ready = 1'b1; redirect = 1'b1; redirect_addr = 12'h500;
      tick();
      out_ready = 1'b0; redirect = 1'b0;
      n_cmp++; if (bus0.out_valid !== 1'b0 || bus0.mem_addr !== 12'h500)
         begin n_err++; $display("FAIL rc_hs: got valid=%0h addr=%h want 0/500", bus0.out_valid, bus0.mem_addr); end
   endtask

   task automatic test_decode();
      logic [15:0] ops  [8] = '{16'h00E0, 16'h00EE, 16'h5121, 16'h8AB8, 16'hF130, 16'hF165, 16'h00FF, 16'h00C5};
      int          exp0 [8] = '{1, 2, 0, 0, 0, 35, 3, 3};
      int          exp1 [8] = '{1, 2, 0, 0, 42, 35, 41, 36};
      logic [11:0] a;
      for (int i = 0; i < 8; i++) begin
         a = 12'h600 + 12'(2 * i);
         put(a, ops[i]);
         goto(a);
         n_cmp++; if (bus0.out_op_id !== 6'(exp0[i]) || bus0.out_illegal !== (exp0[i] == 0))
            begin n_err++; $display("FAIL dec0_%h: got id=%0d ill=%0h want %0d", ops[i], bus0.out_op_id, bus0.out_illegal, exp0[i]); end
         n_cmp++; if (bus1.out_op_id !== 6'(exp1[i]) || bus1.out_illegal !== (exp1[i] == 0))
            begin n_err++; $display("FAIL dec1_%h: got id=%0d ill=%0h want %0d", ops[i], bus1.out_op_id, bus1.out_illegal, exp1[i]); end
      end
   endtask

   task automatic test_random();
      logic [15:0] op;
      logic [11:0] a;
      logic [11:0] nxt;
      int          k;
      for (int it = 0; it < 150; it++) begin
         if ($urandom_range(0, 1) == 1) begin
            k  = $urandom_range(0, pats.size() - 1);
            op = (16'($urandom) & ~pats[k].mask) | pats[k].val;
         end else begin
            op = 16'($urandom);
         end
         a = 12'($urandom);
         put(a, op);
         goto(a);
         n_cmp++; if (bus0.out_valid !== 1'b1 || bus0.out_pc !== a || bus0.out_opcode !== op)
            begin n_err++; $display("FAIL rnd_out: got valid=%0h pc=%h op=%h want 1/%h/%h", bus0.out_valid, bus0.out_pc, bus0.out_opcode, a, op); end
         n_cmp++; if (bus0.out_leader !== op[15:12] || bus0.out_rx !== op[11:8] || bus0.out_ry !== op[7:4] ||
                      bus0.out_nibble !== op[3:0] || bus0.out_imm8 !== op[7:0] || bus0.out_addr !== op[11:0])
            begin n_err++; $display("FAIL rnd_fields: op=%h got l=%h x=%h y=%h n=%h kk=%h nnn=%h", op, bus0.out_leader, bus0.out_rx, bus0.out_ry, bus0.out_nibble, bus0.out_imm8, bus0.out_addr); end
         n_cmp++; if (bus0.out_op_id !== 6'(ref_id(op, 1'b0)) || bus0.out_illegal !== (ref_id(op, 1'b0) == 0))
            begin n_err++; $display("FAIL rnd_id0: op=%h got id=%0d ill=%0h want %0d", op, bus0.out_op_id, bus0.out_illegal, ref_id(op, 1'b0)); end
         n_cmp++; if (bus1.out_op_id !== 6'(ref_id(op, 1'b1)) || bus1.out_illegal !== (ref_id(op, 1'b1) == 0))
            begin n_err++; $display("FAIL rnd_id1: op=%h got id=%0d ill=%0h want %0d", op, bus1.out_op_id, bus1.out_illegal, ref_id(op, 1'b1)); end
         repeat ($urandom_range(0, 2)) begin
            tick();
            n_cmp++; if (bus0.out_valid !== 1'b1 || bus0.out_opcode !== op)
               begin n_err++; $display("FAIL rnd_hold: got valid=%0h op=%h want 1/%h", bus0.out_valid, bus0.out_opcode, op); end
         end
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
         nxt = a + 12'd2;
         n_cmp++; if (bus0.out_valid !== 1'b0 || bus0.mem_addr !== nxt)
            begin n_err++; $display("FAIL rnd_next: got valid=%0h addr=%h want 0/%h", bus0.out_valid, bus0.mem_addr, nxt); end
      end
   endtask

   task automatic test_reset_mid();
      put(12'h200, 16'h1234);
      put(12'h700, 16'h3C12);
      goto(12'h700);
      rst = 1'b1;
      #1;
      n_cmp++; if (bus0.out_valid !== 1'b0 || bus0.out_opcode !== 16'h0)
         begin n_err++; $display("FAIL rm_valid: got valid=%0h op=%h want 0/0000", bus0.out_valid, bus0.out_opcode); end
      tick();
      rst = 1'b0;
      redirect = 1'b1; redirect_addr = 12'h700;
      tick();
      redirect = 1'b0;
      tick(); tick();
      rst = 1'b1;
      #1;
      n_cmp++; if (bus0.out_valid !== 1'b0 || bus0.mem_addr !== 12'h200)
         begin n_err++; $display("FAIL rm_cap: got valid=%0h addr=%h want 0/200", bus0.out_valid, bus0.mem_addr); end
      tick();
      n_cmp++; if (bus0.out_valid !== 1'b0 || bus0.out_opcode !== 16'h0)
         begin n_err++; $display("FAIL rm_hold: got valid=%0h op=%h want 0/0000", bus0.out_valid, bus0.out_opcode); end
      rst = 1'b0;
      #1;
      n_cmp++; if (bus0.mem_rd !== 1'b1 || bus0.mem_addr !== 12'h200)
         begin n_err++; $display("FAIL rm_first: got rd=%0h addr=%h want 1/200", bus0.mem_rd, bus0.mem_addr); end
      tick(); tick(); tick();
      n_cmp++; if (bus0.out_valid !== 1'b1 || bus0.out_pc !== 12'h200 || bus0.out_opcode !== 16'h1234)
         begin n_err++; $display("FAIL rm_refetch: got valid=%0h pc=%h op=%h want 1/200/1234", bus0.out_valid, bus0.out_pc, bus0.out_opcode); end
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
      build_table();
      test_reset();
      test_first_fetch();
      test_stall();
      test_redirect_flo();
      test_wrap();
      test_redirect_cap();
      test_decode();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
